excptn_seq_ctrl: RTL and testbench
==================================

EXCPTN_SEQ_CTRL -- requirements
Module: excptn_seq_ctrl

Interface
REQ-001 SHALL be: one clock; reset is synchronous and active-high.
REQ-002 SHALL have: clk  input  1  rising-edge clock.
REQ-003 SHALL have: rst  input  1  synchronous active-high reset.
REQ-004 SHALL have: ovf_exc_EX  input  1  arithmetic overflow in EX.
REQ-005 SHALL have: undef_exc_ID  input  1  undefined instruction in ID.
REQ-006 SHALL have: irq  input  1  level external interrupt.
REQ-007 SHALL have: irq_en  input  1  global interrupt enable.
REQ-008 SHALL have: eret_ID  input  1  ERET decoded in ID.
REQ-009 SHALL have: pc_plus_4_EX, pc_plus_4_ID  input  32 each  PC+4 of the EX and ID instructions.
REQ-010 SHALL have: flush_IF, flush_ID, flush_EX  output  1 each  one-cycle stage flushes.
REQ-011 SHALL have: pc_redirect  output  1  load redirect_addr into the PC.
REQ-012 SHALL have: redirect_addr  output  32  vector or return address.
REQ-013 SHALL have: epc  output  32  exception PC register.
REQ-014 SHALL have: cause  output  32  cause register, code in [4:0], [31:5]=0.
REQ-015 SHALL have: exl  output  1  exception level, set while in handler.
REQ-016 SHALL have: busy  output  1  high in any state other than IDLE or HANDLER.

Function
REQ-017 SHALL implement FSM states IDLE, ENTER, HANDLER, RETURN.
REQ-018 Event priority SHALL be: ovf_exc_EX > undef_exc_ID > irq.
REQ-019 irq SHALL be accepted only when irq_en=1, exl=0 and state=IDLE.
REQ-020 Sync event at cycle T in IDLE or HANDLER SHALL move the FSM to ENTER at T+1.
REQ-021 ENTER (exactly one cycle) SHALL assert pc_redirect=1 with redirect_addr = vector of the latched event, then go to HANDLER.
REQ-022 Vectors SHALL be: overflow 0x80000180; undef 0x80000000; irq 0x80000200.
REQ-023 Cause codes SHALL be: overflow 12; undef 10; irq 0.
REQ-024 ENTER flushes SHALL be: overflow, flush_IF/ID/EX=1; undef or irq, flush_IF/ID=1 and flush_EX=0.
REQ-025 On acceptance at edge ending T with exl=0: epc SHALL load pc_plus_4_EX-4 (overflow) or pc_plus_4_ID-4 (undef/irq), mod 2^32; cause SHALL load the code.
REQ-026 Sync event accepted in HANDLER (exl=1) SHALL update cause and redirect, but SHALL NOT update epc.
REQ-027 exl SHALL set on entry to ENTER and stay set through HANDLER.
REQ-028 eret_ID in HANDLER SHALL move to RETURN.
REQ-029 RETURN (one cycle) SHALL assert pc_redirect=1, redirect_addr=epc, flush_IF=1, clear exl, then go to IDLE.
REQ-030 eret_ID in IDLE SHALL be ignored, with no outputs and no state change.
REQ-031 Same-cycle eret_ID and sync event in HANDLER SHALL take the event; eret is dropped.
REQ-032 Events arriving while in ENTER or RETURN SHALL be ignored; the pipeline owner holds them via busy.
REQ-033 In IDLE/HANDLER with no event: flush_*, pc_redirect=0 and redirect_addr=0.

Reset
REQ-034 rst SHALL force IDLE, epc=0, cause=0, exl=0, all flushes/pc_redirect/busy=0, redirect_addr=0, including mid-ENTER/RETURN.
REQ-035 All outputs SHALL be registered or decoded from registered state only.

Structure
REQ-036 Package excptn_pkg SHALL hold the state enum, the cause codes, the vector constants and INSTR_NUM_BYTES=4.
REQ-037 The sub-module excptn_prio_enc SHALL implement the combinational priority select: event valid, code, vector, flush mask.

Verification
REQ-038 Overflow: ovf_exc_EX=1, pc_plus_4_EX=0x00400010 -> next cycle pc_redirect=1, redirect_addr=0x80000180, flush_IF/ID/EX=1; epc=0x0040000C, cause=12, exl=1.
REQ-039 Simultaneous: ovf_exc_EX=1, undef_exc_ID=1, irq=1 -> cause=12, vector 0x80000180, single ENTER cycle.
REQ-040 Interrupt masking: irq=1 with irq_en=0 -> no response; with irq_en=1 and pc_plus_4_ID=0x00400020 -> epc=0x0040001C, cause=0, redirect to 0x80000200, flush_EX=0.
REQ-041 Nested/return: undef in HANDLER -> cause=10, epc unchanged; eret_ID -> RETURN with redirect_addr=epc, flush_IF=1, then exl=0 and IDLE.
REQ-042 Reset mid-ENTER: rst=1 during ENTER -> next cycle all outputs 0 and state IDLE; eret_ID in IDLE -> no output.

Source files
------------

// File: rtl/excptn_pkg.sv
// Shared types and constants for the exception sequencing controller.
package excptn_pkg;

  localparam int INSTR_NUM_BYTES = 4;

  localparam logic [31:0] VEC_OVF   = 32'h8000_0180;
  localparam logic [31:0] VEC_UNDEF = 32'h8000_0000;
  localparam logic [31:0] VEC_IRQ   = 32'h8000_0200;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ENTER,
    ST_HANDLER,
    ST_RETURN
  } state_e;

  typedef enum logic [4:0] {
    CAUSE_IRQ   = 5'd0,
    CAUSE_UNDEF = 5'd10,
    CAUSE_OVF   = 5'd12
  } cause_e;

  typedef struct packed {
    logic f_if;
    logic f_id;
    logic f_ex;
  } flush_t;

  // Result of the priority select for one cycle.
  typedef struct packed {
    logic        valid;
    cause_e      code;
    logic [31:0] vector;
    flush_t      flush;
    logic        from_ex;  // faulting instruction lives in EX (else ID)
  } exc_sel_t;

endpackage

// File: rtl/excptn_seq_ctrl_if.sv
// Pipeline <-> exception controller signal bundle.
interface excptn_seq_ctrl_if;
  logic        ovf_exc_EX;
  logic        undef_exc_ID;
  logic        irq;
  logic        irq_en;
  logic        eret_ID;
  logic [31:0] pc_plus_4_EX;
  logic [31:0] pc_plus_4_ID;
  logic        flush_IF;
  logic        flush_ID;
  logic        flush_EX;
  logic        pc_redirect;
  logic [31:0] redirect_addr;
  logic [31:0] epc;
  logic [31:0] cause;
  logic        exl;
  logic        busy;

  // Pipeline side: raises events, consumes flushes and redirects.
  modport master (
    output ovf_exc_EX, undef_exc_ID, irq, irq_en, eret_ID, pc_plus_4_EX, pc_plus_4_ID,
    input  flush_IF, flush_ID, flush_EX, pc_redirect, redirect_addr, epc, cause, exl, busy
  );

  // Controller side.
  modport slave (
    input  ovf_exc_EX, undef_exc_ID, irq, irq_en, eret_ID, pc_plus_4_EX, pc_plus_4_ID,
    output flush_IF, flush_ID, flush_EX, pc_redirect, redirect_addr, epc, cause, exl, busy
  );
endinterface

// File: rtl/excptn_prio_enc.sv
// Combinational priority select: overflow > undefined instruction > interrupt.
module excptn_prio_enc
  import excptn_pkg::*;
(
  input  logic     ovf,
  input  logic     undef,
  input  logic     irq_ok,   // interrupt already qualified by enable/exl/state
  output exc_sel_t sel
);

  // Pick the highest-priority pending event and its vector, code and flush mask.
  always_comb begin
    // NOTE: assigning a full default first keeps every path driven, so no latch is inferred.
    sel = '{valid: 1'b0, code: CAUSE_IRQ, vector: '0, flush: '0, from_ex: 1'b0};
    if (ovf) begin
      sel = '{valid: 1'b1, code: CAUSE_OVF, vector: VEC_OVF,
              flush: '{f_if: 1'b1, f_id: 1'b1, f_ex: 1'b1}, from_ex: 1'b1};
    end else if (undef) begin
      sel = '{valid: 1'b1, code: CAUSE_UNDEF, vector: VEC_UNDEF,
              flush: '{f_if: 1'b1, f_id: 1'b1, f_ex: 1'b0}, from_ex: 1'b0};
    end else if (irq_ok) begin
      sel = '{valid: 1'b1, code: CAUSE_IRQ, vector: VEC_IRQ,
              flush: '{f_if: 1'b1, f_id: 1'b1, f_ex: 1'b0}, from_ex: 1'b0};
    end
  end

endmodule

// File: rtl/excptn_seq_ctrl.sv
// Exception sequencing controller: latches the winning event, redirects the PC
// to its vector for one cycle, tracks EPC/cause/exl and handles ERET.
module excptn_seq_ctrl
  import excptn_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  excptn_seq_ctrl_if.slave   bus
);

  state_e      state_q,  state_d;
  logic [31:0] epc_q,    epc_d;
  logic [4:0]  cause_q,  cause_d;
  logic        exl_q,    exl_d;
  flush_t      flush_q,  flush_d;
  logic        redir_q,  redir_d;
  logic [31:0] raddr_q,  raddr_d;

  exc_sel_t    sel;
  logic        irq_ok;
  logic        can_take;

  // Interrupts are only taken from a quiet IDLE outside a handler.
  assign irq_ok   = bus.irq & bus.irq_en & ~exl_q & (state_q == ST_IDLE);
  assign can_take = (state_q == ST_IDLE) || (state_q == ST_HANDLER);

  excptn_prio_enc u_prio_enc (
    .ovf    (bus.ovf_exc_EX),
    .undef  (bus.undef_exc_ID),
    .irq_ok (irq_ok),
    .sel    (sel)
  );

  // Next-state and next-output computation; outputs are one-cycle pulses
  // loaded for the state being entered.
  always_comb begin
    state_d = state_q;
    epc_d   = epc_q;
    cause_d = cause_q;
    exl_d   = exl_q;
    flush_d = '0;
    redir_d = 1'b0;
    raddr_d = '0;
    unique case (state_q)
      ST_IDLE, ST_HANDLER: begin
        // A sync event wins over a same-cycle ERET.
        if (can_take && sel.valid) begin
          state_d = ST_ENTER;
          cause_d = sel.code;
          exl_d   = 1'b1;
          redir_d = 1'b1;
          raddr_d = sel.vector;
          flush_d = sel.flush;
          // Nested entries keep the original return address.
          if (!exl_q) begin
            epc_d = (sel.from_ex ? bus.pc_plus_4_EX : bus.pc_plus_4_ID)
                    - 32'(INSTR_NUM_BYTES);
          end
        end else if (state_q == ST_HANDLER && bus.eret_ID) begin
          state_d = ST_RETURN;
          redir_d = 1'b1;
          raddr_d = epc_q;
          flush_d = '{f_if: 1'b1, f_id: 1'b0, f_ex: 1'b0};
        end
      end
      ST_ENTER:  state_d = ST_HANDLER;
      ST_RETURN: begin
        state_d = ST_IDLE;
        exl_d   = 1'b0;
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q <= ST_IDLE;
      epc_q   <= '0;
      cause_q <= '0;
      exl_q   <= 1'b0;
      flush_q <= '0;
      redir_q <= 1'b0;
      raddr_q <= '0;
    end else begin
      state_q <= state_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
      exl_q   <= exl_d;
      flush_q <= flush_d;
      redir_q <= redir_d;
      raddr_q <= raddr_d;
    end
  end

  assign bus.flush_IF      = flush_q.f_if;
  assign bus.flush_ID      = flush_q.f_id;
  assign bus.flush_EX      = flush_q.f_ex;
  assign bus.pc_redirect   = redir_q;
  assign bus.redirect_addr = raddr_q;
  assign bus.epc           = epc_q;
  assign bus.cause         = {27'd0, cause_q};
  assign bus.exl           = exl_q;
  assign bus.busy          = (state_q == ST_ENTER) || (state_q == ST_RETURN);

endmodule

// File: tb/tb_excptn_seq_ctrl.sv
// Scoreboard bench for excptn_seq_ctrl: stimulus pushes the expected redirect
// record, a monitor pops and compares whenever pc_redirect is seen.
module tb_excptn_seq_ctrl;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  flush;    // {IF, ID, EX}
    logic [31:0] epc;
    logic [31:0] cause;
    logic        chk_exl;  // entry records also require exl=1
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_total = 0;
  int   n_pass  = 0;
  exp_t sb_q[$];

  excptn_seq_ctrl_if bus();

  excptn_seq_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Outputs of a quiet (IDLE/HANDLER, no event) cycle.
  task automatic check_quiet(string tag, logic exl_exp);
    @(negedge clk);
    check({tag, "_redir"}, {31'd0, bus.pc_redirect}, 32'd0);
    check({tag, "_addr"},  bus.redirect_addr, 32'd0);
    check({tag, "_flush"}, {29'd0, bus.flush_IF, bus.flush_ID, bus.flush_EX}, 32'd0);
    check({tag, "_busy"},  {31'd0, bus.busy}, 32'd0);
    check({tag, "_exl"},   {31'd0, bus.exl}, {31'd0, exl_exp});
  endtask

  // Present an event for one cycle and queue the expected redirect.
  task automatic fire(bit ovf, bit undef, bit irq_i, bit eret,
                      logic [31:0] pex, logic [31:0] pid, exp_t e);
    bus.ovf_exc_EX   = ovf;
    bus.undef_exc_ID = undef;
    bus.irq          = irq_i;
    bus.eret_ID      = eret;
    bus.pc_plus_4_EX = pex;
    bus.pc_plus_4_ID = pid;
    sb_q.push_back(e);
    step();
    bus.ovf_exc_EX   = 1'b0;
    bus.undef_exc_ID = 1'b0;
    bus.irq          = 1'b0;
    bus.eret_ID      = 1'b0;
  endtask

  // ERET from HANDLER, then confirm IDLE with exl cleared.
  task automatic do_return(logic [31:0] epc_exp, logic [31:0] cause_exp, string tag);
    fire(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0,
         '{addr: epc_exp, flush: 3'b100, epc: epc_exp, cause: cause_exp, chk_exl: 1'b0});
    step();
    check_quiet({tag, "_idle"}, 1'b0);
    step();
  endtask

  // Monitor: any redirect must match the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.pc_redirect === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_total++;
          $display("FAIL spurious_redirect: got addr 0x%08h expected no redirect", bus.redirect_addr);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("mon_addr",  bus.redirect_addr, e.addr);
          check("mon_flush", {29'd0, bus.flush_IF, bus.flush_ID, bus.flush_EX}, {29'd0, e.flush});
          check("mon_epc",   bus.epc, e.epc);
          check("mon_cause", bus.cause, e.cause);
          check("mon_busy",  {31'd0, bus.busy}, 32'd1);
          if (e.chk_exl) check("mon_exl", {31'd0, bus.exl}, 32'd1);
        end
      end
    end
  end

  initial begin
    bus.ovf_exc_EX   = 1'b0;
    bus.undef_exc_ID = 1'b0;
    bus.irq          = 1'b0;
    bus.irq_en       = 1'b0;
    bus.eret_ID      = 1'b0;
    bus.pc_plus_4_EX = '0;
    bus.pc_plus_4_ID = '0;
    rst = 1'b1;
    repeat (2) step();
    @(negedge clk);
    check("rst_epc",   bus.epc, 32'd0);
    check("rst_cause", bus.cause, 32'd0);
    check_quiet("rst", 1'b0);
    step();
    rst = 1'b0;
    step();

    // Overflow from IDLE.
    fire(1'b1, 1'b0, 1'b0, 1'b0, 32'h0040_0010, 32'h0,
         '{addr: 32'h8000_0180, flush: 3'b111, epc: 32'h0040_000C, cause: 32'd12, chk_exl: 1'b1});
    step();
    check_quiet("ovf_handler", 1'b1);
    step();
    do_return(32'h0040_000C, 32'd12, "ovf_ret");

    // All three at once: overflow wins, exactly one ENTER cycle.
    bus.irq_en = 1'b1;
    fire(1'b1, 1'b1, 1'b1, 1'b0, 32'h0040_0100, 32'h0040_0200,
         '{addr: 32'h8000_0180, flush: 3'b111, epc: 32'h0040_00FC, cause: 32'd12, chk_exl: 1'b1});
    step();
    check_quiet("sim_handler", 1'b1);
    step();
    do_return(32'h0040_00FC, 32'd12, "sim_ret");

    // Masked interrupt is ignored.
    bus.irq_en = 1'b0;
    bus.irq    = 1'b1;
    repeat (3) check_quiet("irq_masked", 1'b0);
    step();
    bus.irq_en = 1'b1;
    fire(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0040_0020,
         '{addr: 32'h8000_0200, flush: 3'b110, epc: 32'h0040_001C, cause: 32'd0, chk_exl: 1'b1});
    step();
    check_quiet("irq_handler", 1'b1);
    step();

    // Nested undef with same-cycle ERET: event wins, epc kept.
    fire(1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0050_0000,
         '{addr: 32'h8000_0000, flush: 3'b110, epc: 32'h0040_001C, cause: 32'd10, chk_exl: 1'b1});
    step();
    check_quiet("nest_handler", 1'b1);
    step();
    do_return(32'h0040_001C, 32'd10, "nest_ret");

    // EPC wraps when PC+4 is zero.
    fire(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0,
         '{addr: 32'h8000_0000, flush: 3'b110, epc: 32'hFFFF_FFFC, cause: 32'd10, chk_exl: 1'b1});
    step();
    step();
    do_return(32'hFFFF_FFFC, 32'd10, "wrap_ret");

    // Reset in the middle of ENTER.
    fire(1'b1, 1'b0, 1'b0, 1'b0, 32'h0040_0010, 32'h0,
         '{addr: 32'h8000_0180, flush: 3'b111, epc: 32'h0040_000C, cause: 32'd12, chk_exl: 1'b1});
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_epc",   bus.epc, 32'd0);
    check("mid_rst_cause", bus.cause, 32'd0);
    check_quiet("mid_rst", 1'b0);

    // ERET in IDLE does nothing.
    step();
    bus.eret_ID = 1'b1;
    repeat (3) check_quiet("eret_idle", 1'b0);
    check("eret_idle_epc", bus.epc, 32'd0);
    bus.eret_ID = 1'b0;

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) step();
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
